// File: rtl/simple_pkg.sv
// Shared fetch-path constants and the fetch queue entry layout.
package simple_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_IW = 16;

    typedef struct packed {
        logic [DEF_AW-1:0] pc;
        logic [DEF_IW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue: synchronous push/pop/flush, head shown as zero when empty.
module fetch_fifo #(
    parameter int AW    = 16,
    parameter int IW    = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic [IW-1:0] push_instr,
    input  logic          pop,
    output logic [AW-1:0] head_pc,
    output logic [IW-1:0] head_instr,
    output logic [CW-1:0] count
);

    logic [AW-1:0] pc_mem  [DEPTH];
    logic [IW-1:0] ins_mem [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok, push_ok;

    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && !flush;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PW'(1);
            if (pop_ok)  rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            pc_mem[wr_q]  <= push_pc;
            ins_mem[wr_q] <= push_instr;
        end
    end

    assign count      = count_q;
    assign head_pc    = (count_q == '0) ? '0 : pc_mem[rd_q];
    assign head_instr = (count_q == '0) ? '0 : ins_mem[rd_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited PC sequencer feeding fetch_fifo,
// with branch redirect flushing both the queue and any response in flight.
module fetch_queue
    import simple_pkg::*;
#(
    parameter int          AW       = DEF_AW,
    parameter int          IW       = DEF_IW,
    parameter int          DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 redirect,
    input  logic signed [AW-1:0] redirect_pc,
    input  logic signed [AW-1:0] redirect_offset,
    output logic [AW-1:0]        mem_address,
    output logic                 mem_rden,
    input  logic [IW-1:0]        mem_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        operation,
    output logic [AW-1:0]        pcout
);

    logic [AW-1:0] pc_q, pc_d, req_pc_q, req_pc_d, target;
    logic          inflight_q, inflight_d, stale_q, stale_d;
    logic          issue, push, pop;
    logic [CW-1:0] count;

    always_comb begin
        target = redirect_pc + redirect_offset + AW'(1);
        // Count the outstanding response as occupied so a push never hits a full queue.
        issue  = !reset && !redirect && ((int'(count) + int'(inflight_q)) < DEPTH);
        push   = inflight_q && !stale_q && !redirect;
        pop    = out_valid && out_ready && !redirect;

        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        stale_d    = inflight_q && redirect;
        if (redirect) begin
            pc_d = target;
        end else if (issue) begin
            pc_d     = pc_q + AW'(1);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    fetch_fifo #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_pc    (req_pc_q),
        .push_instr (mem_q),
        .pop        (pop),
        .head_pc    (pcout),
        .head_instr (operation),
        .count      (count)
    );

    assign mem_rden    = issue;
    assign mem_address = pc_q;
    assign out_valid   = (count != '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue against a memory returning addr+0x100.
module tb_fetch_queue;
    import simple_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] redirect_offset = '0;
    logic [15:0] mem_q = '0;
    logic [15:0] mem_address;
    logic        mem_rden;
    logic        out_valid;
    logic [15:0] operation;
    logic [15:0] pcout;

    fetch_queue dut (
        .clock           (clock),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .redirect_offset (redirect_offset),
        .mem_address     (mem_address),
        .mem_rden        (mem_rden),
        .mem_q           (mem_q),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .operation       (operation),
        .pcout           (pcout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_q <= mem_address + 16'h0100;

    fetch_entry_t sb[$];
    fetch_entry_t mon_e;
    int checks = 0;
    int failures = 0;
    int pops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_stream(input logic [15:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 16'(i);
            e.instr = e.pc + 16'h0100;
            sb.push_back(e);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready && !redirect) begin
            pops++;
            if (sb.size() == 0) begin
                chk("sb_extra_pop", 32'(sb.size()), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("pcout", 32'(pcout), 32'(mon_e.pc));
                chk("operation", 32'(operation), 32'(mon_e.instr));
            end
        end
    end

    initial begin
        int p0;
        // Reset values
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_op", 32'(operation), 0);
        chk("rst_pc", 32'(pcout), 0);
        chk("rst_rden", 32'(mem_rden), 0);
        step();
        step();

        // Release with consumer always ready: fill latency and throughput
        out_ready = 1'b1;
        expect_stream(16'h0000, 40);
        reset = 1'b0;
        #1;
        chk("a_rden", 32'(mem_rden), 1);
        chk("a_addr", 32'(mem_address), 0);
        chk("a_valid_c1", 32'(out_valid), 0);
        step();
        chk("a_valid_c2", 32'(out_valid), 0);
        step();
        chk("a_valid_c3", 32'(out_valid), 1);
        chk("a_first_pc", 32'(pcout), 0);
        chk("a_first_op", 32'(operation), 32'h100);
        p0 = pops;
        repeat (10) step();
        chk("a_throughput", 32'(pops - p0), 10);

        // Asynchronous reset between edges with a response in flight
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("d_valid", 32'(out_valid), 0);
        chk("d_op", 32'(operation), 0);
        chk("d_pc", 32'(pcout), 0);
        chk("d_rden", 32'(mem_rden), 0);
        expect_stream(16'h0000, 20);
        reset = 1'b0;
        #1;
        chk("d_req_rden", 32'(mem_rden), 1);
        chk("d_req_addr", 32'(mem_address), 0);
        step();
        chk("d_valid_c2", 32'(out_valid), 0);
        step();
        chk("d_valid_c3", 32'(out_valid), 1);
        chk("d_first_pc", 32'(pcout), 0);
        repeat (4) step();

        // Back-pressure: queue saturates, nothing lost
        reset = 1'b1;
        out_ready = 1'b0;
        sb.delete();
        step();
        reset = 1'b0;
        expect_stream(16'h0000, 20);
        repeat (10) step();
        chk("bp_rden", 32'(mem_rden), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_head", 32'(pcout), 0);
        p0 = pops;
        out_ready = 1'b1;
        repeat (8) step();
        chk("bp_drained", 32'(pops - p0), 8);

        // Redirect with three queued entries, response in flight and out_ready=1
        reset = 1'b1;
        out_ready = 1'b0;
        sb.delete();
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("b_nonempty", 32'(out_valid), 1);
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        redirect_offset = 16'h0005;
        out_ready = 1'b1;
        sb.delete();
        expect_stream(16'h0016, 12);
        #1;
        chk("b_rden_redir", 32'(mem_rden), 0);
        step();
        redirect = 1'b0;
        #1;
        chk("b_rden", 32'(mem_rden), 1);
        chk("b_addr", 32'(mem_address), 32'h16);
        chk("b_valid_c1", 32'(out_valid), 0);
        step();
        chk("b_valid_c2", 32'(out_valid), 0);
        step();
        chk("b_valid_c3", 32'(out_valid), 1);
        chk("b_target_pc", 32'(pcout), 32'h16);
        repeat (5) step();

        // Redirect arithmetic wrapping to 0xFFFF, then PC wrap to 0x0000
        redirect = 1'b1;
        redirect_pc = 16'h7FFF;
        redirect_offset = 16'h7FFF;
        sb.delete();
        expect_stream(16'hFFFF, 12);
        step();
        redirect = 1'b0;
        #1;
        chk("c_addr0", 32'(mem_address), 32'hFFFF);
        step();
        chk("c_addr1", 32'(mem_address), 0);
        step();
        chk("c_head", 32'(pcout), 32'hFFFF);
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
